circular_shifter_pipe: RTL

- Parametrised, pipelined lane-rotator for the matrix-multiply datapath.
- Rotates a vector of LANES words of LANE_W bits by a per-beat step, either up or down.
- Three per-beat modes: circular rotate, zero-fill logical shift, or bypass.
- Log2 barrel stages, one register per stage; valid/ready handshake with full backpressure. Sits between the operand buffers and the PE array.

---
 rtl/circular_shifter_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/circular_shifter_pipe.sv
// circular_shifter_pipe: pipelined lane rotator for the matrix-multiply datapath.
// A capture register followed by STEP_W barrel stages; stage k moves the vector
// by 2^k lanes when bit k of the beat's step is set. Each beat carries its own
// mode sideband down the pipe, and a stall freezes every stage including bubbles.
module circular_shifter_pipe #(
    parameter int unsigned LANES  = 33,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned STEP_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES*LANE_W-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     shift_direction,
    input  logic [STEP_W-1:0]        step_size,
    input  logic                     fill_zero,
    input  logic                     direct_connection,
    output logic [LANES*LANE_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int unsigned VW = LANES * LANE_W;

    // Stage 0 is the capture register; stages 1..STEP_W hold barrel outputs.
    logic [VW-1:0]     r_data [STEP_W+1];
    logic [STEP_W:0]   r_valid;
    // Sideband exists only for stages that still feed a barrel level.
    logic [STEP_W-1:0] r_dir;
    logic [STEP_W-1:0] r_fill;
    logic [STEP_W-1:0] r_byp;
    logic [STEP_W-1:0] r_step [STEP_W];

    logic [VW-1:0]     w_shifted [STEP_W];
    logic              w_stall;

    // One barrel level: move by 2^k lanes (mod LANES when rotating).
    function automatic logic [VW-1:0] stage_shift(
        input logic [VW-1:0] v,
        input int unsigned   k,
        input logic          dir,
        input logic          fill
    );
        logic [VW-1:0] o;
        int unsigned   amt;
        int unsigned   rot;
        int unsigned   src;
        logic          ok;
        o   = '0;
        amt = 32'd1 << k;
        rot = amt % LANES;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (fill) begin
                if (dir) begin
                    ok  = (i >= amt);
                    src = ok ? (i - amt) : 0;
                end else begin
                    ok  = ((i + amt) < LANES);
                    src = ok ? (i + amt) : 0;
                end
            end else begin
                ok  = 1'b1;
                src = dir ? ((i + LANES - rot) % LANES) : ((i + rot) % LANES);
            end
            o[i*LANE_W +: LANE_W] = ok ? v[src*LANE_W +: LANE_W] : '0;
        end
        return o;
    endfunction

    assign w_stall   = r_valid[STEP_W] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_valid[STEP_W];
    assign out_data  = r_data[STEP_W];
    assign busy      = |r_valid;

    // Barrel levels: shift only when this stage's step bit is set and not bypassing.
    always_comb begin
        for (int unsigned k = 0; k < STEP_W; k++) begin
            w_shifted[k] = r_data[k];
            if (r_step[k][k] && !r_byp[k]) begin
                w_shifted[k] = stage_shift(r_data[k], k, r_dir[k], r_fill[k]);
            end
        end
    end

    // Pipeline registers: advance all stages together unless the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dir   <= '0;
            r_fill  <= '0;
            r_byp   <= '0;
            for (int unsigned j = 0; j <= STEP_W; j++) begin
                r_data[j] <= '0;
            end
            for (int unsigned j = 0; j < STEP_W; j++) begin
                r_step[j] <= '0;
            end
        end else if (!w_stall) begin
            r_valid <= {r_valid[STEP_W-1:0], in_valid};
            if (in_valid) begin
                r_data[0] <= in_data;
                r_dir[0]  <= shift_direction;
                r_fill[0] <= fill_zero;
                r_byp[0]  <= direct_connection;
                r_step[0] <= step_size;
            end
            // Data only moves with a valid beat so the output holds its last result.
            for (int unsigned j = 1; j <= STEP_W; j++) begin
                if (r_valid[j-1]) begin
                    r_data[j] <= w_shifted[j-1];
                end
            end
            for (int unsigned j = 1; j < STEP_W; j++) begin
                if (r_valid[j-1]) begin
                    r_dir[j]  <= r_dir[j-1];
                    r_fill[j] <= r_fill[j-1];
                    r_byp[j]  <= r_byp[j-1];
                    r_step[j] <= r_step[j-1];
                end
            end
        end
    end

endmodule
